// File: rtl/mem_responder_if.sv
// Request/response bundle between an initiator and the mem_responder.
interface mem_responder_if;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic        err;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, stall, done, err
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, stall, done, err
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder with an IDLE/BUSY/RESP handshake.
// Optional odd-address fault detection is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned ADDR_BITS = 8
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);

  localparam int unsigned Words   = 1 << ADDR_BITS;
  localparam logic [3:0]  LoadCnt = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   req_wr_q;
  logic [ADDR_BITS-1:0]   req_idx_q;
  logic [15:0]            req_data_q;
  logic                   req_fault_q;
  logic                   in_fault;
  logic                   accept;

  logic [15:0]            mem [Words];

  logic                   commit_we;
  logic [ADDR_BITS-1:0]   commit_idx;
  logic [15:0]            commit_data;
  logic                   commit_fault;

  assign accept = bus.enable && (state_q != StBusy);

`ifdef MEM_ALIGN_CHECK_EN
  assign in_fault = bus.addr[0];
`else
  assign in_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StBusy;
            cnt_d   = LoadCnt;
          end
        end else if (state_q == StResp) begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_wr_q    <= 1'b0;
      req_idx_q   <= '0;
      req_data_q  <= '0;
      req_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        req_wr_q    <= bus.wr;
        req_idx_q   <= bus.addr[ADDR_BITS:1];
        req_data_q  <= bus.data_in;
        req_fault_q <= in_fault;
      end
    end
  end

  // The commit happens on the edge entering RESP; with LATENCY=1 that is the
  // acceptance edge itself, so the live inputs are used instead of the registers.
  always_comb begin
    commit_we    = 1'b0;
    commit_idx   = req_idx_q;
    commit_data  = req_data_q;
    commit_fault = req_fault_q;
    if (LATENCY == 1) begin
      commit_we    = accept && bus.wr;
      commit_idx   = bus.addr[ADDR_BITS:1];
      commit_data  = bus.data_in;
      commit_fault = in_fault;
    end else begin
      commit_we = (state_q == StBusy) && (cnt_q == 4'd1) && req_wr_q;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (commit_we && !commit_fault) begin
      mem[commit_idx] <= commit_data;
    end
  end

  always_comb begin
    bus.stall    = (state_q == StBusy);
    bus.done     = (state_q == StResp);
    bus.data_out = '0;
    bus.err      = 1'b0;
    if (state_q == StResp) begin
      if (req_fault_q) begin
        bus.err = 1'b1;
      end else if (!req_wr_q) begin
        bus.data_out = mem[req_idx_q];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=4, ADDR_BITS=8).
module tb_mem_responder;

  localparam int unsigned Lat = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mem_responder_if bus ();

  mem_responder #(
    .LATENCY  (Lat),
    .ADDR_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents a request, lets it be accepted, then scrambles the inputs.
  task automatic start(input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.enable  = 1'b1;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge clk); #1;
    bus.enable  = 1'b0;
    bus.wr      = ~w;
    bus.addr    = ~a;
    bus.data_in = ~d;
  endtask

  // Called at cycle 1 after acceptance; returns sampled in the done cycle.
  task automatic finish_txn(input string tag, input logic exp_err, input logic [15:0] exp_dout);
    for (int i = 1; i < Lat; i++) begin
      check({tag, " stall"}, 16'(bus.stall), 16'd1);
      check({tag, " early done"}, 16'(bus.done), 16'd0);
      @(posedge clk); #1;
    end
    check({tag, " done"}, 16'(bus.done), 16'd1);
    check({tag, " stall@done"}, 16'(bus.stall), 16'd0);
    check({tag, " err"}, 16'(bus.err), 16'(exp_err));
    check({tag, " data"}, bus.data_out, exp_dout);
  endtask

  task automatic to_idle(input string tag);
    @(posedge clk); #1;
    check({tag, " idle done"}, 16'(bus.done), 16'd0);
    check({tag, " idle stall"}, 16'(bus.stall), 16'd0);
    check({tag, " idle data"}, bus.data_out, 16'd0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.wr      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    #2 rst = 1'b0;
    #1;
    check("reset stall", 16'(bus.stall), 16'd0);
    check("reset done", 16'(bus.done), 16'd0);
    check("reset err", 16'(bus.err), 16'd0);
    check("reset data", bus.data_out, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Write then back-to-back read of the same word.
    start(1'b1, 16'h0010, 16'h1234);
    finish_txn("wr 0010", 1'b0, 16'h0000);
    start(1'b0, 16'h0010, 16'h0000);
    finish_txn("b2b rd 0010", 1'b0, 16'h1234);
    to_idle("after b2b");

    // Request raised during BUSY and dropped before stall clears is ignored.
    start(1'b0, 16'h0010, 16'h0000);
    bus.enable  = 1'b1;
    bus.wr      = 1'b1;
    bus.addr    = 16'h0010;
    bus.data_in = 16'hDEAD;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    check("ignored stall c2", 16'(bus.stall), 16'd1);
    @(posedge clk); #1;
    check("ignored stall c3", 16'(bus.stall), 16'd1);
    @(posedge clk); #1;
    check("ignored rd done", 16'(bus.done), 16'd1);
    check("ignored rd data", bus.data_out, 16'h1234);
    to_idle("ignored");
    start(1'b0, 16'h0010, 16'h0000);
    finish_txn("rd after ignored", 1'b0, 16'h1234);
    to_idle("rd after ignored");

    // Reset mid-write abandons the write.
    start(1'b1, 16'h0020, 16'h1111);
    finish_txn("wr 0020", 1'b0, 16'h0000);
    to_idle("wr 0020");
    start(1'b1, 16'h0020, 16'hBEEF);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid rst stall", 16'(bus.stall), 16'd0);
    check("mid rst done", 16'(bus.done), 16'd0);
    check("mid rst data", bus.data_out, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("post rst no done", 16'(bus.done), 16'd0);
      @(posedge clk); #1;
    end
    start(1'b0, 16'h0020, 16'h0000);
    finish_txn("rd 0020 after rst", 1'b0, 16'h1111);
    to_idle("rd 0020");

    // Index wraps modulo 2^ADDR_BITS.
    start(1'b1, 16'h0202, 16'hA5A5);
    finish_txn("wr 0202", 1'b0, 16'h0000);
    to_idle("wr 0202");
    start(1'b0, 16'h0002, 16'h0000);
    finish_txn("rd 0002 wrap", 1'b0, 16'hA5A5);
    to_idle("rd 0002");

    // Odd address write.
`ifdef MEM_ALIGN_CHECK_EN
    start(1'b1, 16'h0011, 16'hFFFF);
    finish_txn("wr 0011 fault", 1'b1, 16'h0000);
    to_idle("wr 0011");
    check("fault err cleared", 16'(bus.err), 16'd0);
    start(1'b0, 16'h0010, 16'h0000);
    finish_txn("rd 0010 unchanged", 1'b0, 16'h1234);
`else
    start(1'b1, 16'h0011, 16'hFFFF);
    finish_txn("wr 0011", 1'b0, 16'h0000);
    to_idle("wr 0011");
    start(1'b0, 16'h0010, 16'h0000);
    finish_txn("rd 0010 odd wr", 1'b0, 16'hFFFF);
`endif
    to_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
